gene_evolve_ctrl: RTL and testbench

GENE_EVOLVE_CTRL -- requirements
Module: gene_evolve_ctrl

---
 rtl/evolve_pkg.sv | 38 +++
 rtl/gene_attr_mutator.sv | 26 ++
 rtl/gene_evolve_ctrl.sv | 154 +++++++++++++++
 tb/tb_gene_evolve_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evolve_pkg.sv
// Shared gene field layout, FSM state encoding and type constants for the gene evolution controller.
// The MUT states exist only when GENE_EVOLVE_MUTATION_EN is defined.
package evolve_pkg;

  localparam int unsigned KEY_LSB   = 48;
  localparam int unsigned KEY_W     = 16;
  localparam int unsigned TYPE_BIT  = 47;
  localparam int unsigned ATTR_W    = 8;
  localparam int unsigned ATTR1_LSB = 16;
  localparam int unsigned ATTR2_LSB = 8;
  localparam int unsigned ATTR3_LSB = 0;

  localparam logic [7:0] HALF      = 8'h40;
  localparam logic       TYPE_NODE = 1'b0;
  localparam logic       TYPE_CONN = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StXover,
    StOut
`ifdef GENE_EVOLVE_MUTATION_EN
    , StMut1,
    StMut2,
    StMut3
`endif
  } state_e;

  // Bit offset of attribute 1..3 inside a gene word.
  function automatic int unsigned attr_lsb(logic [1:0] idx);
    unique case (idx)
      2'd1:    return ATTR1_LSB;
      2'd2:    return ATTR2_LSB;
      default: return ATTR3_LSB;
    endcase
  endfunction

endpackage

// File: rtl/gene_attr_mutator.sv
// Combinational replacement value for one gene attribute, chosen by gene type and attribute index.
module gene_attr_mutator
  import evolve_pkg::*;
(
  input  logic [7:0] rand_val,
  input  logic       gene_type,
  input  logic [1:0] attr_idx,
  output logic [7:0] attr_val
);

  always_comb begin
    attr_val = 8'h00;
    if (gene_type == TYPE_NODE) begin
      unique case (attr_idx)
        2'd1:    attr_val = rand_val;
        2'd2:    attr_val = {4'b0, rand_val[3:0]};
        2'd3:    attr_val = {5'b0, rand_val[2:0]};
        default: attr_val = 8'h00;
      endcase
    end else if (attr_idx == 2'd1) begin
      // Connection genes only carry an enable flag in attr1.
      attr_val = {7'b0, rand_val[0]};
    end
  end

endmodule

// File: rtl/gene_evolve_ctrl.sv
// Crossover/mutation controller producing one child genome from two parent gene streams.
// Define GENE_EVOLVE_MUTATION_EN to build the three per-attribute mutation stages.
module gene_evolve_ctrl
  import evolve_pkg::*;
#(
  parameter int unsigned GENE_W = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_genes,
  input  logic              bias,
  input  logic [7:0]        mutation_prob,
  input  logic [7:0]        rand_val,
  output logic              rand_next,
  input  logic [GENE_W-1:0] p1_gene,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [GENE_W-1:0] p2_gene,
  input  logic              p2_valid,
  output logic              p2_ready,
  output logic [GENE_W-1:0] child_gene,
  output logic              child_valid,
  input  logic              child_ready,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  num_genes_q, idx_q, idx_inc;
  logic              bias_q, done_q;
  logic              pair_acc, out_acc, last_gene, take_p2;
  logic [GENE_W-1:0] p1_q, p2_q, gene_q;

  assign idx_inc   = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_gene = (idx_inc == num_genes_q);
  assign pair_acc  = (state_q == StFetch) && p1_valid && p2_valid;
  assign out_acc   = (state_q == StOut) && child_ready;
  assign take_p2   = !bias_q && (rand_val > HALF);

`ifdef GENE_EVOLVE_MUTATION_EN
  logic [7:0] mprob_q, mut_val;
  logic [1:0] attr_idx;
  logic       mut_hit;

  // attr_idx == 0 means no mutation stage is active.
  always_comb begin
    attr_idx = 2'd0;
    unique case (state_q)
      StMut1:  attr_idx = 2'd1;
      StMut2:  attr_idx = 2'd2;
      StMut3:  attr_idx = 2'd3;
      default: attr_idx = 2'd0;
    endcase
  end

  assign mut_hit = (attr_idx != 2'd0) && (rand_val <= mprob_q);

  gene_attr_mutator u_mutator (
    .rand_val  (rand_val),
    .gene_type (gene_q[TYPE_BIT]),
    .attr_idx  (attr_idx),
    .attr_val  (mut_val)
  );
`else
  logic unused_mprob;
  assign unused_mprob = ^mutation_prob;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && (num_genes != '0)) state_d = StFetch;
      StFetch: if (pair_acc) state_d = StXover;
`ifdef GENE_EVOLVE_MUTATION_EN
      StXover: state_d = StMut1;
      StMut1:  state_d = StMut2;
      StMut2:  state_d = StMut3;
      StMut3:  state_d = StOut;
`else
      StXover: state_d = StOut;
`endif
      StOut:   if (child_ready) state_d = last_gene ? StIdle : StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_genes_q <= '0;
      bias_q      <= 1'b0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      gene_q      <= '0;
`ifdef GENE_EVOLVE_MUTATION_EN
      mprob_q     <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      if ((state_q == StIdle) && start) begin
        num_genes_q <= num_genes;
        bias_q      <= bias;
        idx_q       <= '0;
        done_q      <= (num_genes == '0);
`ifdef GENE_EVOLVE_MUTATION_EN
        mprob_q     <= mutation_prob;
`endif
      end
      if (pair_acc) begin
        p1_q <= p1_gene;
        p2_q <= p2_gene;
      end
      if (state_q == StXover) begin
        gene_q <= take_p2 ? p2_q : p1_q;
      end
`ifdef GENE_EVOLVE_MUTATION_EN
      if (mut_hit) begin
        gene_q[attr_lsb(attr_idx) +: ATTR_W] <= mut_val;
      end
`endif
      if (out_acc) begin
        idx_q  <= idx_inc;
        done_q <= last_gene;
      end
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    p1_ready    = (state_q == StFetch);
    p2_ready    = (state_q == StFetch);
    child_valid = (state_q == StOut);
    child_gene  = gene_q;
    done        = done_q;
`ifdef GENE_EVOLVE_MUTATION_EN
    rand_next   = (state_q == StXover) || (attr_idx != 2'd0);
`else
    rand_next   = (state_q == StXover);
`endif
  end

endmodule

// File: tb/tb_gene_evolve_ctrl.sv
// Self-checking bench for gene_evolve_ctrl: transaction-level model plus directed literal checks.
module tb_gene_evolve_ctrl;

`ifdef GENE_EVOLVE_MUTATION_EN
  localparam int NSTEP  = 4;
  localparam bit MUT_EN = 1'b1;
`else
  localparam int NSTEP  = 1;
  localparam bit MUT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_genes = 8'd0;
  logic        bias = 1'b0;
  logic [7:0]  mutation_prob = 8'h00;
  logic [7:0]  rand_val = 8'h00;
  logic        rand_next;
  logic [63:0] p1_gene = 64'h0;
  logic        p1_valid = 1'b0;
  logic        p1_ready;
  logic [63:0] p2_gene = 64'h0;
  logic        p2_valid = 1'b0;
  logic        p2_ready;
  logic [63:0] child_gene;
  logic        child_valid;
  logic        child_ready = 1'b1;
  logic        busy;
  logic        done;

  gene_evolve_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_genes     (num_genes),
    .bias          (bias),
    .mutation_prob (mutation_prob),
    .rand_val      (rand_val),
    .rand_next     (rand_next),
    .p1_gene       (p1_gene),
    .p1_valid      (p1_valid),
    .p1_ready      (p1_ready),
    .p2_gene       (p2_gene),
    .p2_valid      (p2_valid),
    .p2_ready      (p2_ready),
    .child_gene    (child_gene),
    .child_valid   (child_valid),
    .child_ready   (child_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Child from the rules: crossover pick, then each attribute optionally replaced.
  function automatic logic [63:0] model_child(input logic [63:0] a1, input logic [63:0] a2,
                                              input bit b, input logic [7:0] mp,
                                              input logic [7:0] r0, input logic [7:0] r1,
                                              input logic [7:0] r2, input logic [7:0] r3);
    logic [63:0] c, cm;
    logic [7:0]  rr [3];
    c = (!b && (r0 > 8'h40)) ? a2 : a1;
    cm = c;
    rr[0] = r1; rr[1] = r2; rr[2] = r3;
    for (int n = 0; n < 3; n++) begin
      if (rr[n] <= mp) begin
        if (c[47] == 1'b0) begin
          if (n == 0) cm[23:16] = rr[n];
          if (n == 1) cm[15:8]  = rr[n] % 16;
          if (n == 2) cm[7:0]   = rr[n] % 8;
        end else begin
          if (n == 0) cm[23:16] = rr[n] % 2;
          if (n == 1) cm[15:8]  = 8'h00;
          if (n == 2) cm[7:0]   = 8'h00;
        end
      end
    end
    return MUT_EN ? cm : c;
  endfunction

  // Model: 0 idle, 1 waiting for a parent pair, 2 consuming randoms, 3 presenting child.
  int          m_mode = 0;
  int          m_k = 0;
  logic [7:0]  m_num = 8'd0, m_idx = 8'd0, m_mp = 8'd0;
  bit          m_bias = 1'b0, m_done = 1'b0;
  logic [63:0] m_a1 = 64'h0, m_a2 = 64'h0, m_child = 64'h0;
  logic [7:0]  m_r [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_done = 1'b0; m_num = 8'd0; m_idx = 8'd0; m_k = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        0: if (start) begin
          m_num = num_genes; m_bias = bias; m_mp = mutation_prob; m_idx = 8'd0;
          if (num_genes == 8'd0) m_done = 1'b1;
          else m_mode = 1;
        end
        1: if (p1_valid && p2_valid) begin
          m_a1 = p1_gene; m_a2 = p2_gene; m_k = 0; m_mode = 2;
        end
        2: begin
          m_r[m_k] = rand_val;
          m_k++;
          if (m_k == NSTEP) begin
            m_child = model_child(m_a1, m_a2, m_bias, m_mp, m_r[0], m_r[1], m_r[2], m_r[3]);
            m_mode = 3;
          end
        end
        default: if (child_ready) begin
          m_idx++;
          if (m_idx == m_num) begin m_mode = 0; m_done = 1'b1; end
          else m_mode = 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rand_next", rand_next, 0);
      chk("rst_ready", {p1_ready, p2_ready}, 0);
      chk("rst_child_valid", child_valid, 0);
      chk("rst_child_gene", child_gene, 0);
    end else begin
      chk("busy", busy, m_mode != 0);
      chk("done", done, m_done);
      chk("rand_next", rand_next, m_mode == 2);
      chk("p1_ready", p1_ready, m_mode == 1);
      chk("p2_ready", p2_ready, m_mode == 1);
      chk("child_valid", child_valid, m_mode == 3);
      if (m_mode == 3) chk("child_gene", child_gene, m_child);
    end
  end

  int          rn_cnt = 0;
  int          dn_cnt = 0;
  logic [63:0] got [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rand_next) rn_cnt++;
      if (done) dn_cnt++;
      if (child_valid && child_ready) got.push_back(child_gene);
    end
  end

  bit rand_rnd = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rnd) rand_val = 8'($urandom_range(0, 255));
  end

  logic [63:0] ga1 [8];
  logic [63:0] ga2 [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n, input bit b, input logic [7:0] mp);
    num_genes = n; bias = b; mutation_prob = mp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] g1, input logic [63:0] g2);
    int t = 0;
    p1_gene = g1; p2_gene = g2; p1_valid = 1'b1; p2_valid = 1'b1;
    while (!p1_ready && t < 100) begin tick(); t++; end
    if (t >= 100) chk("feed_timeout", 1, 0);
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin tick(); t++; end
    if (t >= 200) chk("idle_timeout", 1, 0);
    tick(); tick();
  endtask

  task automatic run(input int n, input bit b, input logic [7:0] mp);
    got.delete();
    do_start(8'(n), b, mp);
    for (int i = 0; i < n; i++) feed(ga1[i], ga2[i]);
    wait_idle();
  endtask

  int rn0, dn0, t0;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Bias to parent 1, no mutation possible.
    ga1[0] = 64'hAAAA_0000_0001_0203; ga2[0] = 64'hCCCC_0000_0F0F_0F0F;
    ga1[1] = 64'hBBBB_8000_0004_0506; ga2[1] = 64'hDDDD_8000_0E0E_0E0E;
    rand_val = 8'hFF; rn0 = rn_cnt; dn0 = dn_cnt;
    run(2, 1'b1, 8'h00);
    chk("bias_count", got.size(), 2);
    chk("bias_child0", got[0], 64'hAAAA_0000_0001_0203);
    chk("bias_child1", got[1], 64'hBBBB_8000_0004_0506);
    chk("bias_done_pulses", dn_cnt - dn0, 1);
`ifdef GENE_EVOLVE_MUTATION_EN
    chk("bias_rand_next", rn_cnt - rn0, 8);
`else
    chk("bias_rand_next", rn_cnt - rn0, 2);
`endif

    // Crossover threshold: strictly above HALF selects parent 2.
    ga1[0] = 64'h1111_0000_0010_2030; ga2[0] = 64'h2222_8000_0040_5060;
    rand_val = 8'h41;
    run(1, 1'b0, 8'h00);
    chk("xover_41", got[0], 64'h2222_8000_0040_5060);
    rand_val = 8'h40;
    run(1, 1'b0, 8'h00);
    chk("xover_40", got[0], 64'h1111_0000_0010_2030);

    // Attribute replacement for node and conn genes.
    ga1[0] = 64'h1234_0000_77AA_BBCC; ga2[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    ga1[1] = 64'h5678_8001_9911_2233; ga2[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    rand_val = 8'h5A;
    run(2, 1'b1, 8'h80);
`ifdef GENE_EVOLVE_MUTATION_EN
    chk("mut_node", got[0], 64'h1234_0000_775A_0A02);
    chk("mut_conn", got[1], 64'h5678_8001_9900_0000);
`else
    chk("mut_node", got[0], 64'h1234_0000_77AA_BBCC);
    chk("mut_conn", got[1], 64'h5678_8001_9911_2233);
`endif

    // One-sided valid, start while busy, and a stalled output.
    got.delete();
    rand_val = 8'h10; dn0 = dn_cnt;
    do_start(8'd1, 1'b0, 8'h00);
    p1_gene = 64'h0A0A_0000_0102_0304; p1_valid = 1'b1; p2_valid = 1'b0;
    start = 1'b1; num_genes = 8'd5;
    rn0 = rn_cnt;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("onesided_still_fetch", p1_ready, 1);
    chk("onesided_no_rand", rn_cnt - rn0, 0);
    p1_valid = 1'b0;
    child_ready = 1'b0;
    feed(64'h0A0A_0000_0102_0304, 64'h0B0B_8000_0506_0708);
    t0 = 0;
    while (!child_valid && t0 < 50) begin tick(); t0++; end
    if (t0 >= 50) chk("stall_timeout", 1, 0);
    rn0 = rn_cnt;
    repeat (10) tick();
    chk("stall_gene", child_gene, 64'h0A0A_0000_0102_0304);
    chk("stall_valid", child_valid, 1);
    chk("stall_no_fetch", p1_ready, 0);
    chk("stall_no_rand", rn_cnt - rn0, 0);
    child_ready = 1'b1;
    wait_idle();
    chk("stall_count", got.size(), 1);
    chk("stall_done", dn_cnt - dn0, 1);

    // Randomised rand_val stream, model-checked.
    for (int i = 0; i < 8; i++) begin
      ga1[i] = {16'(i * 16'h1111), (i % 2 == 1) ? 16'h8000 : 16'h0000, 32'(i * 32'h0103_0507)};
      ga2[i] = {16'(16'hF000 + i), (i % 3 == 0) ? 16'h8000 : 16'h0001, 32'(i * 32'h1020_3040)};
    end
    rand_rnd = 1'b1;
    run(4, 1'b0, 8'h60);
    chk("rand_count", got.size(), 4);

    // Asynchronous reset mid-genome, then a full 8-gene genome.
    do_start(8'd8, 1'b0, 8'h80);
    feed(ga1[0], ga2[0]);
    feed(ga1[1], ga2[1]);
    feed(ga1[2], ga2[2]);
`ifdef GENE_EVOLVE_MUTATION_EN
    tick(); tick();
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_outputs", {done, rand_next, p1_ready, p2_ready, child_valid}, 0);
    chk("arst_gene", child_gene, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    dn0 = dn_cnt;
    run(8, 1'b0, 8'h80);
    chk("post_rst_count", got.size(), 8);
    chk("post_rst_done", dn_cnt - dn0, 1);
    rand_rnd = 1'b0;

    // Zero-length genome.
    dn0 = dn_cnt;
    do_start(8'd0, 1'b0, 8'h00);
    chk("zero_busy", busy, 0);
    tick(); tick();
    chk("zero_done", dn_cnt - dn0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
